// File: rtl/div_meter_pkg.sv
`default_nettype none
// ============================================================================
// div_meter_pkg : shared FSM state type and default sizing for div_clock_meter
// Rev 1.0
// ============================================================================
package div_meter_pkg;

    typedef enum logic [0:0] {
        WAIT_FIRST = 1'b0,
        COUNTING   = 1'b1
    } meter_state_e;

    localparam int DEF_CNT_WIDTH      = 24;
    localparam int DEF_TIMEOUT_CYCLES = 200000;

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// bit_sync : two-flop synchronizer for a single asynchronous bit, reset to 0
// Rev 1.0
// ============================================================================
module bit_sync (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/div_clock_meter.sv
`default_nettype none
// ============================================================================
// div_clock_meter : edge ticks and rising-to-rising period of a slow clock.
// Optional stall detection enabled by macro CLK_METER_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module div_clock_meter
    import div_meter_pkg::*;
#(
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 slow_in,
    output logic                 rise_tick,
    output logic                 fall_tick,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 stalled
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 sync_w;
    logic                 armed_w;
    logic                 hist_q;
    logic [1:0]           fill_q;
    logic                 rise_q;
    logic                 fall_q;
    meter_state_e         state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] period_q;
    logic                 period_valid_q;

    bit_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (slow_in),
        .q_o   (sync_w)
    );

    // Edges are only trusted once the synchronizer and history flop hold real samples.
    assign armed_w = (fill_q == 2'd3);
    assign cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q <= 1'b0;
            fill_q <= 2'd0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            hist_q <= sync_w;
            if (!armed_w) begin
                fill_q <= fill_q + 2'd1;
            end
            rise_q <= armed_w &  sync_w & ~hist_q;
            fall_q <= armed_w & ~sync_w &  hist_q;
        end
    end

`ifdef CLK_METER_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_M1 = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    logic stalled_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= WAIT_FIRST;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
`ifdef CLK_METER_TIMEOUT_EN
            stalled_q      <= 1'b0;
`endif
        end else begin
            period_valid_q <= 1'b0;
            case (state_q)
                WAIT_FIRST: begin
                    if (rise_q) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= COUNTING;
`ifdef CLK_METER_TIMEOUT_EN
                        stalled_q <= 1'b0;
`endif
                    end
                end
                COUNTING: begin
                    if (rise_q) begin
                        period_q       <= cnt_q;
                        period_valid_q <= 1'b1;
                        cnt_q          <= CNT_ONE;
`ifdef CLK_METER_TIMEOUT_EN
                    end else if (cnt_q == TIMEOUT_M1) begin
                        cnt_q     <= cnt_d;
                        state_q   <= WAIT_FIRST;
                        stalled_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= WAIT_FIRST;
            endcase
        end
    end

    assign rise_tick    = rise_q;
    assign fall_tick    = fall_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
`ifdef CLK_METER_TIMEOUT_EN
    assign stalled      = stalled_q;
`else
    assign stalled      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/div_clock_meter.md
DIV_CLOCK_METER -- requirements
Module: div_clock_meter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 24, giving the width of the period counter and period output.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200000, giving the clock cycles without a rising edge before a stall is declared; legal range 2 to 2^CNT_WIDTH-1.
REQ-003 SHALL have port clock  input  1  the single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port slow_in  input  1  the divided clock under measurement, asynchronous to clock.
REQ-006 SHALL have port rise_tick  output  1  one-cycle pulse per synchronized rising edge of slow_in.
REQ-007 SHALL have port fall_tick  output  1  one-cycle pulse per synchronized falling edge of slow_in.
REQ-008 SHALL have port period  output  CNT_WIDTH  the last measured rising-to-rising interval, in clock cycles.
REQ-009 SHALL have port period_valid  output  1  one-cycle pulse when period is updated.
REQ-010 SHALL have port stalled  output  1  level output, high while slow_in has had no rising edge for TIMEOUT_CYCLES.

Function
REQ-011 SHALL pass slow_in through a two-flop synchronizer, then one edge-history flop, before any use.
REQ-012 SHALL assert rise_tick for exactly one cycle when the synchronized value is 1 and the history flop is 0; latency is 3 clocks from a slow_in change.
REQ-013 SHALL assert fall_tick for exactly one cycle when the synchronized value is 0 and the history flop is 1.
REQ-014 SHALL implement an FSM with two states, WAIT_FIRST and COUNTING; reset enters WAIT_FIRST.
REQ-015 In WAIT_FIRST, on rise_tick, SHALL clear the counter to 1, move to COUNTING, and leave period and period_valid unchanged.
REQ-016 In COUNTING, without rise_tick, SHALL increment the counter by 1 per cycle, saturating at 2^CNT_WIDTH-1 with no wrap.
REQ-017 In COUNTING, on rise_tick, SHALL load period with the current counter value, pulse period_valid for one cycle, and reset the counter to 1.
REQ-018 The period value SHALL equal the number of clock cycles between two consecutive rise_tick assertions.
REQ-019 SHALL treat rise_tick on the same cycle as counter saturation as a normal edge: period gets the saturated value and period_valid pulses.
REQ-020 rise_tick and fall_tick SHALL never assert on the same cycle.

Reset
REQ-021 While reset is high, all of the following SHALL be 0: synchronizer flops, history flop, counter, period, period_valid, rise_tick, fall_tick, stalled; the FSM SHALL be in WAIT_FIRST.
REQ-022 Reset asserted mid-measurement SHALL discard the partial count; the first rising edge after reset SHALL NOT produce period_valid.
REQ-023 A slow_in level of 1 at reset release SHALL NOT generate rise_tick; the history flop is compared only after the synchronizer has filled.

Configuration
REQ-024 With macro CLK_METER_TIMEOUT_EN defined, SHALL apply REQ-025 and REQ-026.
REQ-025 When the counter reaches TIMEOUT_CYCLES in COUNTING, SHALL set stalled to 1, return to WAIT_FIRST, and hold period.
REQ-026 SHALL clear stalled on the next rise_tick, on the same cycle the FSM enters COUNTING.
REQ-027 Without CLK_METER_TIMEOUT_EN, stalled SHALL be tied to 0, no timeout logic SHALL exist, and the counter SHALL only saturate.

Structure
REQ-028 A shared package div_meter_pkg SHALL hold:
- the FSM state enum (WAIT_FIRST, COUNTING);
- the default CNT_WIDTH and TIMEOUT_CYCLES constants.
REQ-029 The synchronizer SHALL be a sub-module named bit_sync: two flops, synchronous active-high reset, reset value 0.

Verification
REQ-030 slow_in toggling every 2 clocks (period 4) -> rise_tick every 4 cycles; period=4 with period_valid from the second rising edge onward.
REQ-031 slow_in high 3 clocks, then low 5 clocks (period 8) -> period=8; fall_tick exactly 3 cycles after each rise_tick.
REQ-032 Reset pulsed mid-period, then period-6 input -> no period_valid at the first edge after reset; period=6 at the second.
REQ-033 CLK_METER_TIMEOUT_EN defined, TIMEOUT_CYCLES=20, slow_in held low after edges at period 4:
- stalled rises 20 cycles after the last rise_tick, with period still 4;
- on the next edge, stalled clears and no period_valid is produced.
REQ-034 CNT_WIDTH=4, macro undefined, slow_in period 40 -> period=15 (saturated), stalled stays 0.
REQ-035 slow_in held at 1 across reset release -> no rise_tick until a 0-to-1 transition occurs.
